// File: rtl/sram_like_resp.sv
// SRAM-like request/response memory responder: in-order queue, fixed-latency completion.
// Define SRAM_LIKE_RESP_RANDOM_STALL_EN to randomly withhold addr_ok via an 8-bit LFSR.
module sram_like_resp #(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [2:0]    LAT  = 3'(LATENCY);
   localparam logic [CW-1:0] FULL = CW'(QDEPTH);

   typedef struct packed {
      logic        is_wr;
      logic [31:0] data;
      logic [2:0]  age;
   } entry_t;

   logic [31:0]       mem [2**ADDR_W];
   entry_t            q_q [QDEPTH];
   logic [PW-1:0]     rd_ptr_q, wr_ptr_q, nh_ptr;
   logic [CW-1:0]     cnt_q, cnt_d, cnt_rem;
   logic              data_ok_q, data_ok_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W-1:0] idx;
   logic              accept, pop;
   entry_t            new_e;
   logic              unused_ok;

   assign idx       = addr[ADDR_W+1:2];
   assign accept    = req & addr_ok;
   assign unused_ok = ^{size, addr[31:ADDR_W+2], addr[1:0]};

`ifdef SRAM_LIKE_RESP_RANDOM_STALL_EN
   logic [7:0] lfsr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= 8'h5A;
      else       lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   assign addr_ok = (cnt_q != FULL) & ~lfsr_q[0];
`else
   assign addr_ok = (cnt_q != FULL);
`endif

   // Byte-enabled write at acceptance; contents survive reset.
   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   // data_ok is registered, so decide here whether the entry that heads the queue
   // next cycle will have reached LATENCY by then.
   always_comb begin
      new_e     = '{is_wr: wr, data: (wr ? 32'h0 : mem[idx]), age: 3'd1};
      pop       = data_ok_q;
      nh_ptr    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_rem   = cnt_q - CW'(pop);
      cnt_d     = cnt_rem + CW'(accept);
      data_ok_d = 1'b0;
      rdata_d   = 32'h0;
      if (cnt_rem != '0) begin
         if (q_q[nh_ptr].age >= LAT - 3'd1) begin
            data_ok_d = 1'b1;
            rdata_d   = q_q[nh_ptr].is_wr ? 32'h0 : q_q[nh_ptr].data;
         end
      end else if (accept && LATENCY == 1) begin
         data_ok_d = 1'b1;
         rdata_d   = new_e.data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         data_ok_q <= 1'b0;
         rdata_q   <= 32'h0;
         for (int i = 0; i < QDEPTH; i++) q_q[i] <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++)
            q_q[i].age <= (q_q[i].age < LAT) ? q_q[i].age + 3'd1 : LAT;
         if (accept) q_q[wr_ptr_q] <= new_e;
         wr_ptr_q  <= wr_ptr_q + PW'(accept);
         rd_ptr_q  <= nh_ptr;
         cnt_q     <= cnt_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
      end
   end

   assign data_ok = data_ok_q;
   assign rdata   = rdata_q;

endmodule
